// File: rtl/rr_arb_mux.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_arb_mux : registered N:1 valid/ready arbitrating mux, round-robin or
//              fixed priority, with optional packet lock.       Rev 1.0
// -----------------------------------------------------------------------------
module rr_arb_mux #(
  parameter int BITWIDTH  = 16,
  parameter int NUM_INPUT = 8,
  parameter int SEL_WIDTH = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1,
  parameter int MODE      = 0,
  parameter int LOCK      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BITWIDTH*NUM_INPUT-1:0] in_bus,
  input  logic [NUM_INPUT-1:0]          in_valid,
  input  logic [NUM_INPUT-1:0]          in_last,
  output logic [NUM_INPUT-1:0]          in_ready,
  output logic [BITWIDTH-1:0]           out_data,
  output logic [SEL_WIDTH-1:0]          out_sel,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam logic [SEL_WIDTH:0]   C_N       = (SEL_WIDTH+1)'(NUM_INPUT);
  localparam logic [SEL_WIDTH-1:0] C_LAST_CH = SEL_WIDTH'(NUM_INPUT-1);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] lock_ch;
  logic [SEL_WIDTH-1:0] cand;
  logic [SEL_WIDTH:0]   idx;
  logic                 cand_vld;
  logic                 cand_last;
  logic                 load;
  logic                 accept;
  logic [BITWIDTH-1:0]  ch_data [NUM_INPUT];

  generate
    for (genvar i = 0; i < NUM_INPUT; i++) begin : g_unpack
      assign ch_data[i] = in_bus[BITWIDTH*i +: BITWIDTH];
    end
  endgenerate

  // Loops run from the far end so the nearest valid channel is the last writer.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    idx      = '0;
    if (state == ST_LOCKED) begin
      cand     = lock_ch;
      cand_vld = in_valid[lock_ch];
    end else if (MODE == 1) begin
      for (int i = NUM_INPUT-1; i >= 0; i--) begin
        if (in_valid[i]) begin
          cand     = SEL_WIDTH'(i);
          cand_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_INPUT-1; k >= 0; k--) begin
        idx = {1'b0, ptr} + (SEL_WIDTH+1)'(k);
        if (idx >= C_N) begin
          idx = idx - C_N;
        end
        if (in_valid[idx[SEL_WIDTH-1:0]]) begin
          cand     = idx[SEL_WIDTH-1:0];
          cand_vld = 1'b1;
        end
      end
    end
  end

  assign cand_last = in_last[cand];
  assign load      = !out_valid || out_ready;
  assign accept    = load && cand_vld && !reset;

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[cand] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      ptr       <= '0;
      lock_ch   <= '0;
      state     <= ST_UNLOCKED;
    end else if (load) begin
      if (cand_vld) begin
        out_data  <= ch_data[cand];
        out_sel   <= cand;
        out_last  <= (LOCK != 0) ? cand_last : 1'b0;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
      // With packet lock the pointer only advances past a completed packet.
      if (cand_vld && (MODE == 0) && ((LOCK == 0) || cand_last)) begin
        ptr <= (cand == C_LAST_CH) ? '0 : cand + 1'b1;
      end
      if (cand_vld && (LOCK != 0)) begin
        case (state)
          ST_UNLOCKED: begin
            if (!cand_last) begin
              state   <= ST_LOCKED;
              lock_ch <= cand;
            end
          end
          ST_LOCKED: begin
            if (cand_last) begin
              state <= ST_UNLOCKED;
            end
          end
          default: state <= ST_UNLOCKED;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// Bench for rr_arb_mux: three 4-channel instances (round-robin, fixed priority,
// round-robin with packet lock) checked through per-instance scoreboards.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_bus;

  logic [3:0]  va, la, vb, lb, vc, lc;
  logic        ra, rb, rc;
  logic [3:0]  a_rdy, b_rdy, c_rdy;
  logic [15:0] a_dat, b_dat, c_dat;
  logic [1:0]  a_sel, b_sel, c_sel;
  logic        a_last, b_last, c_last;
  logic        a_vld, b_vld, c_vld;

  int total = 0;
  int bad   = 0;

  logic [18:0] qa[$];
  logic [18:0] qb[$];
  logic [18:0] qc[$];

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic [3:0] rdy;
    logic [1:0] sel;
    logic       last;
  } step_t;

  step_t tbl [6];

  always #5 clk = ~clk;

  rr_arb_mux #(.BITWIDTH(16), .NUM_INPUT(4), .MODE(0), .LOCK(0)) u_rr (
    .clk(clk), .reset(reset), .in_bus(in_bus), .in_valid(va), .in_last(la),
    .in_ready(a_rdy), .out_data(a_dat), .out_sel(a_sel), .out_last(a_last),
    .out_valid(a_vld), .out_ready(ra));

  rr_arb_mux #(.BITWIDTH(16), .NUM_INPUT(4), .MODE(1), .LOCK(0)) u_fp (
    .clk(clk), .reset(reset), .in_bus(in_bus), .in_valid(vb), .in_last(lb),
    .in_ready(b_rdy), .out_data(b_dat), .out_sel(b_sel), .out_last(b_last),
    .out_valid(b_vld), .out_ready(rb));

  rr_arb_mux #(.BITWIDTH(16), .NUM_INPUT(4), .MODE(0), .LOCK(1)) u_lk (
    .clk(clk), .reset(reset), .in_bus(in_bus), .in_valid(vc), .in_last(lc),
    .in_ready(c_rdy), .out_data(c_dat), .out_sel(c_sel), .out_last(c_last),
    .out_valid(c_vld), .out_ready(rc));

  function automatic logic [18:0] beat(input int s, input logic last);
    logic [1:0]  sv;
    logic [15:0] dv;
    sv = 2'(s);
    dv = 16'h00A0 + 16'(s);
    return {sv, dv, last};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a beat is consumed on the edge after a negedge that
  // sees out_valid && out_ready.
  always @(negedge clk) begin
    if (!reset && a_vld && ra) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL A_beat: got unexpected %h, required none", {a_sel, a_dat, a_last});
      end else chk("A_beat", {13'b0, a_sel, a_dat, a_last}, {13'b0, qa.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!reset && b_vld && rb) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL B_beat: got unexpected %h, required none", {b_sel, b_dat, b_last});
      end else chk("B_beat", {13'b0, b_sel, b_dat, b_last}, {13'b0, qb.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!reset && c_vld && rc) begin
      if (qc.size() == 0) begin
        total++; bad++;
        $display("FAIL C_beat: got unexpected %h, required none", {c_sel, c_dat, c_last});
      end else chk("C_beat", {13'b0, c_sel, c_dat, c_last}, {13'b0, qc.pop_front()});
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) in_bus[16*i +: 16] = 16'h00A0 + 16'(i);
    va = 4'b1111; la = 4'b1111; ra = 1'b1;
    vb = 4'b1111; lb = 4'b0000; rb = 1'b1;
    vc = 4'b1111; lc = 4'b0000; rc = 1'b1;

    // Lock table: single-beat ch0, 3-beat packet on ch2, then ch3 (ptr=3), ch0.
    tbl[0] = '{v: 4'b0001, l: 4'b0001, rdy: 4'b0001, sel: 2'd0, last: 1'b1};
    tbl[1] = '{v: 4'b0101, l: 4'b0000, rdy: 4'b0100, sel: 2'd2, last: 1'b0};
    tbl[2] = '{v: 4'b0101, l: 4'b0000, rdy: 4'b0100, sel: 2'd2, last: 1'b0};
    tbl[3] = '{v: 4'b0101, l: 4'b0100, rdy: 4'b0100, sel: 2'd2, last: 1'b1};
    tbl[4] = '{v: 4'b1001, l: 4'b1001, rdy: 4'b1000, sel: 2'd3, last: 1'b1};
    tbl[5] = '{v: 4'b1001, l: 4'b1001, rdy: 4'b0001, sel: 2'd0, last: 1'b1};

    // Reset with all channels valid.
    #1 reset = 1'b1;
    #1;
    chk("rst_a_valid", 32'(a_vld), 32'd0);
    chk("rst_a_data",  32'(a_dat), 32'd0);
    chk("rst_a_ready", 32'(a_rdy), 32'd0);
    chk("rst_c_ready", 32'(c_rdy), 32'd0);
    chk("rst_c_sel",   32'(c_sel), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    vb = 4'b0000;
    vc = 4'b0000;
    #1;

    // Round-robin fairness.
    for (int i = 0; i < 6; i++) begin
      chk("rr_ready", 32'(a_rdy), 32'(4'b0001 << (i % 4)));
      qa.push_back(beat(i % 4, 1'b0));
      tick();
    end
    va = 4'b0000;
    tick();
    chk("rr_idle_valid", 32'(a_vld), 32'd0);

    // Back-pressure: ptr is 2 here.
    va = 4'b1111;
    #1;
    chk("bp_ready_first", 32'(a_rdy), 32'(4'b0100));
    qa.push_back(beat(2, 1'b0));
    tick();
    ra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_ready", 32'(a_rdy), 32'd0);
      chk("bp_stall_data",  32'(a_dat), 32'h00A2);
      chk("bp_stall_sel",   32'(a_sel), 32'd2);
      chk("bp_stall_valid", 32'(a_vld), 32'd1);
      tick();
    end
    ra = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_rdy), 32'(4'b1000));
    qa.push_back(beat(3, 1'b0));
    tick();
    chk("bp_no_bubble", 32'({a_vld, a_sel}), 32'({1'b1, 2'd3}));
    va = 4'b0000;
    tick();

    // Fixed priority.
    vb = 4'b1010;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("fp_ready", 32'(b_rdy), 32'(4'b0010));
      qb.push_back(beat(1, 1'b0));
      tick();
    end
    vb = 4'b0000;
    tick();

    // Packet lock.
    for (int i = 0; i < 6; i++) begin
      vc = tbl[i].v;
      lc = tbl[i].l;
      #1;
      chk("lk_ready", 32'(c_rdy), 32'(tbl[i].rdy));
      qc.push_back(beat(int'(tbl[i].sel), tbl[i].last));
      tick();
    end
    vc = 4'b0000;
    tick();

    // Reset mid-packet: ptr is 1, ch2 starts a packet and gets locked.
    vc = 4'b0100;
    lc = 4'b0000;
    #1;
    chk("mid_ready", 32'(c_rdy), 32'(4'b0100));
    tick();
    chk("mid_valid_before", 32'(c_vld), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_valid_reset", 32'(c_vld), 32'd0);
    chk("mid_ready_reset", 32'(c_rdy), 32'd0);
    vc = 4'b0101;
    lc = 4'b0001;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_after_ready", 32'(c_rdy), 32'(4'b0001));
    qc.push_back(beat(0, 1'b1));
    tick();
    vc = 4'b0000;
    tick();

    repeat (3) tick();
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    chk("qc_empty", 32'(qc.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arb_mux.md
# rr_arb_mux

Registered N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output. It selects one requesting channel per cycle by round-robin or fixed priority, optionally locked for a multi-beat packet, and registers the winner's data. It sits in front of any shared datapath resource (writeback bus, memory port, shared ALU) where the purely combinational muxes are insufficient because sources arrive independently and must be back-pressured.

## Interface
- BITWIDTH, 16, data width per channel
- NUM_INPUT, 8, number of input channels, ≥1
- SEL_WIDTH, $clog2(NUM_INPUT) (1 when NUM_INPUT=1), width of grant index
- MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
- LOCK, 0, 1 = hold grant on a channel until a beat with its in_last bit is accepted

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_bus  input  BITWIDTH*NUM_INPUT  packed channel data; channel i at [BITWIDTH*(i+1)-1 : BITWIDTH*i]
- in_valid  input  NUM_INPUT  per-channel valid
- in_last  input  NUM_INPUT  per-channel end-of-packet; ignored when LOCK=0
- in_ready  output  NUM_INPUT  per-channel ready; at most one bit high
- out_data  output  BITWIDTH  registered winning data
- out_sel  output  SEL_WIDTH  index of channel that produced out_data
- out_last  output  1  registered in_last of winning beat (0 when LOCK=0)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accept

## Operation
- A transfer occurs on channel i when in_valid[i] && in_ready[i] at a rising clk edge; on the output when out_valid && out_ready.
- Internal state: ptr (SEL_WIDTH), locked (1), lock_ch (SEL_WIDTH), and the output register (out_data, out_sel, out_last, out_valid).
- load = !out_valid || out_ready (output register is empty or being drained this cycle).
- Grant (combinational):
  - locked=1: the candidate is lock_ch only; other channels wait even if valid.
  - MODE=0: the candidate is the first valid channel scanning ptr, ptr+1, … NUM_INPUT-1, 0, … ptr-1.
  - MODE=1: the candidate is the lowest-index valid channel.
- in_ready[g] = load && in_valid[g] for granted g; all other bits 0. in_ready is never asserted for a channel whose in_valid is 0.
- On a clock edge with load=1:
  - If a grant exists: out_data←channel g data, out_sel←g, out_last←(LOCK ? in_last[g] : 0), out_valid←1.
  - If no grant exists: out_valid←0. out_data, out_sel and out_last hold.
- ptr update (MODE=0): on an accepted beat, ptr←(g==NUM_INPUT-1) ? 0 : g+1. With LOCK=1, ptr updates only on the beat where in_last[g]=1. ptr is unused in MODE=1.
- Lock FSM (LOCK=1 only), two states:
  - UNLOCKED→LOCKED on an accepted beat with in_last[g]=0; lock_ch←g.
  - LOCKED→UNLOCKED on an accepted beat with in_last[lock_ch]=1.
  - When LOCK=0, the FSM stays UNLOCKED permanently.
- Stall: when out_valid=1 and out_ready=0, all in_ready bits are 0 and all registers hold.

## Timing
- Reset (asynchronous, immediate): out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, locked=0, lock_ch=0. in_ready is therefore all 0 only while reset is high; it follows the grant logic in the first cycle after release.
- Latency: an input beat accepted at edge k is presented on out_* from edge k until it is drained.
- Throughput: one beat per cycle sustained while out_ready=1.
- in_ready depends combinationally on in_valid, out_ready and state. No input depends combinationally on any output.
- Simultaneous drain and load on the same edge: the new beat replaces the old one with no bubble.
- Reset asserted mid-packet: the lock is cleared and the in-flight output beat is discarded (out_valid→0 asynchronously).
- NUM_INPUT=1: ptr stays 0 and the block behaves as a one-entry pipeline register.

## Test plan
- Reset: with all in_valid=1, assert reset → out_valid=0, out_data=0, in_ready=0 during reset; the first edge after release grants channel 0 (ptr=0).
- Round-robin fairness (NUM_INPUT=4, MODE=0, out_ready=1, in_valid=4'b1111, channel i data=16'h00A0+i) → out_sel sequence 0,1,2,3,0 on consecutive cycles, wrapping 3→0; out_data matches channel.
- Fixed priority (MODE=1, in_valid=4'b1010) → out_sel=1 every cycle; in_ready=4'b0010; channel 3 never granted.
- Back-pressure: out_ready=0 for 3 cycles while out_valid=1 → in_ready=0, out_data and out_sel stable; out_ready=1 → held beat drains and the next grant loads on the same edge.
- Packet lock (LOCK=1, MODE=0): channel 2 sends 3 beats with last on the 3rd, channel 0 is valid throughout → out_sel=2,2,2 then 0; ptr=3 after the packet.
- Reset mid-packet (LOCK=1, after beat 1 of 3) → out_valid=0 immediately; after release, grant starts from channel 0 with no lock held.
